// File: rtl/lzc_pkg.sv
// Shared types and helpers for the sequential leading-zero counter.
// Holds the FSM state encoding, the count-width helper and the
// DATA_W/SEG_W legality check used at elaboration time.
package lzc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width needed to hold a zero count of 0..width inclusive.
   function automatic int cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

   // Segment must tile the word exactly and be a power of two >= 2.
   function automatic bit seg_w_legal(input int data_w, input int seg_w);
      return (seg_w >= 2) && ((seg_w & (seg_w - 1)) == 0) &&
             ((data_w % seg_w) == 0);
   endfunction

endpackage

// File: rtl/lzc_seg.sv
// Combinational leading-zero count of one SEG_W-bit segment.
// Z holds the zero count above the highest set bit; it is only meaningful
// when n_V is high (n_V is low exactly when A is all zeros).
module lzc_seg #(
   parameter int SEG_W = 16,
   localparam int Z_W  = $clog2(SEG_W)
) (
   input  logic [SEG_W-1:0] A,
   output logic [Z_W-1:0]   Z,
   output logic             n_V
);

   // Scan from the LSB upwards so the highest set bit is assigned last.
   always_comb begin
      Z   = '0;
      n_V = |A;
      for (int i = 0; i < SEG_W; i++) begin
         if (A[i]) begin
            Z = Z_W'(SEG_W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/lzc_seq_ctrl.sv
// Multi-cycle leading-zero counter and normalizer.
// One SEG_W-bit LZC segment is time-shared across the word, MSB slice
// first, accumulating the zero count. The result is the count, an
// all-zero flag and the word shifted left by the count.
// Build option: LZC_SEQ_EARLY_EXIT_EN ends the scan in the cycle the first
// non-zero segment is found; otherwise the scan always takes NSEG cycles.
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; valid is never withdrawn before that edge, and the
// payload is held stable while valid is high and ready is low.
module lzc_seq_ctrl
   import lzc_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int SEG_W  = 16,
   localparam int CNT_W = cnt_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_zero,
   output logic [DATA_W-1:0] out_norm
);

   localparam int NSEG  = DATA_W / SEG_W;
   localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int Z_W   = $clog2(SEG_W);

   generate
      if (!seg_w_legal(DATA_W, SEG_W)) begin : g_bad_cfg
         $error("lzc_seq_ctrl: DATA_W must be a multiple of SEG_W, SEG_W a power of 2 >= 2");
      end
   endgenerate

   state_t             state, state_next;
   logic [DATA_W-1:0]  w_q, d_q, norm_q;
   logic [CNT_W-1:0]   acc_q, acc_next;
   logic [IDX_W-1:0]   idx_q;
   logic               found_q, found_next;
   logic [SEG_W-1:0]   seg;
   logic [Z_W-1:0]     seg_z;
   logic               seg_nz;
   logic               last_seg;
   logic               scan_exit;

   assign seg = w_q[DATA_W-1 -: SEG_W];

   lzc_seg #(.SEG_W(SEG_W)) u_seg (
      .A   (seg),
      .Z   (seg_z),
      .n_V (seg_nz)
   );

   // Accumulate only until the first non-zero segment; later slices are ignored.
   always_comb begin
      acc_next   = acc_q;
      found_next = found_q;
      if (!found_q) begin
         if (seg_nz) begin
            acc_next   = acc_q + CNT_W'(seg_z);
            found_next = 1'b1;
         end else begin
            acc_next = acc_q + CNT_W'(SEG_W);
         end
      end
   end

   assign last_seg = (idx_q == IDX_W'(NSEG - 1));

`ifdef LZC_SEQ_EARLY_EXIT_EN
   assign scan_exit = last_seg || found_next;
`else
   assign scan_exit = last_seg;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = SCAN;
         SCAN:    if (scan_exit) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture on accept, shift/accumulate while scanning,
   // register the normalized word on the final scan edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q     <= '0;
         d_q     <= '0;
         norm_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         found_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  w_q     <= in_data;
                  d_q     <= in_data;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  found_q <= 1'b0;
               end
            end
            SCAN: begin
               w_q     <= w_q << SEG_W;
               idx_q   <= idx_q + 1'b1;
               acc_q   <= acc_next;
               found_q <= found_next;
               if (scan_exit) begin
                  norm_q <= found_next ? (d_q << acc_next) : '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_count = acc_q;
   assign out_zero  = (state == DONE) && !found_q;
   assign out_norm  = norm_q;

endmodule

// File: tb/tb_lzc_seq_ctrl.sv
// Self-checking bench for lzc_seq_ctrl (DATA_W=64, SEG_W=16).
// Results are predicted by an MSB-down bit-scan model at acceptance time
// and compared when the block presents them.
module tb_lzc_seq_ctrl;

   localparam int DATA_W = 64;
   localparam int SEG_W  = 16;
   localparam int NSEG   = DATA_W / SEG_W;
   localparam int CNT_W  = 7;
   localparam int EXP_W  = 1 + CNT_W + DATA_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CNT_W-1:0]  out_count;
   logic              out_zero;
   logic [DATA_W-1:0] out_norm;

   int checks   = 0;
   int failures = 0;
   int n_acc    = 0;
   int n_out    = 0;
   bit rand_done;

   logic [EXP_W-1:0] exp_q[$];

   lzc_seq_ctrl #(.DATA_W(DATA_W), .SEG_W(SEG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .out_zero  (out_zero),
      .out_norm  (out_norm)
   );

   // Clock.
   always #5 clk = ~clk;

   // Reference: scan bits from the MSB down, stop at the first one.
   function automatic logic [EXP_W-1:0] model(input logic [DATA_W-1:0] d);
      int  c;
      bit  hit;
      logic [DATA_W-1:0] n;
      c   = DATA_W;
      hit = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (!hit && d[i]) begin
            c   = DATA_W - 1 - i;
            hit = 1'b1;
         end
      end
      n = hit ? (d << c) : '0;
      return {~hit, CNT_W'(c), n};
   endfunction

   // Expected number of scan cycles for the build under test.
   function automatic int exp_lat(input logic [DATA_W-1:0] d);
`ifdef LZC_SEQ_EARLY_EXIT_EN
      for (int k = 0; k < NSEG; k++) begin
         if (d[DATA_W - 1 - k*SEG_W -: SEG_W] != '0) return k + 1;
      end
      return NSEG;
`else
      return NSEG;
`endif
   endfunction

   // Scoreboard: push on input acceptance, pop/compare on output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_data));
            n_acc++;
         end
         if (out_valid && out_ready) begin
            logic [EXP_W-1:0] e;
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got count=%0d norm=%h with no word outstanding",
                        out_count, out_norm);
            end else begin
               e = exp_q.pop_front();
               if ({out_zero, out_count, out_norm} !== e) begin
                  failures++;
                  $display("FAIL sb_result: got zero=%b count=%0d norm=%h, want zero=%b count=%0d norm=%h",
                           out_zero, out_count, out_norm,
                           e[EXP_W-1], e[DATA_W +: CNT_W], e[DATA_W-1:0]);
               end
            end
         end
      end
   end

   // Driver: present a word and hold it until accepted (bounded).
   task automatic send_word(input logic [DATA_W-1:0] d);
      int n;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_count, out_zero, out_norm} !== {1'b1, 1'b0, 7'd0, 1'b0, 64'd0}) begin
         failures++;
         $display("FAIL reset_values: got ready=%b valid=%b count=%0d zero=%b norm=%h, want 1 0 0 0 0",
                  in_ready, out_valid, out_count, out_zero, out_norm);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Single word with out_ready high: latency and value checked inline.
   task automatic test_directed(input string name, input logic [DATA_W-1:0] d,
                                input logic [CNT_W-1:0] e_cnt, input logic e_zero,
                                input logic [DATA_W-1:0] e_norm);
      int lat;
      out_ready = 1'b1;
      send_word(d);
      lat = 0;
      while (lat < 50) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) break;
      end
      checks++;
      if (lat !== exp_lat(d) || !out_valid) begin
         failures++;
         $display("FAIL %s_latency: got %0d edges (valid=%b), want %0d", name, lat, out_valid, exp_lat(d));
      end
      checks++;
      if ({out_zero, out_count, out_norm} !== {e_zero, e_cnt, e_norm}) begin
         failures++;
         $display("FAIL %s_value: got zero=%b count=%0d norm=%h, want zero=%b count=%0d norm=%h",
                  name, out_zero, out_count, out_norm, e_zero, e_cnt, e_norm);
      end
      @(posedge clk);
      #1;
   endtask

   // Consumer stalls for 5 cycles; a competing input must be ignored.
   task automatic test_hold();
      int n;
      out_ready = 1'b0;
      send_word(64'h0000_0000_0000_0001);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b1;
      in_data  = 64'hFFFF_0000_0000_0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, in_ready, out_count, out_zero, out_norm} !==
             {1'b1, 1'b0, 7'd63, 1'b0, 64'h8000_0000_0000_0000}) begin
            failures++;
            $display("FAIL hold_cycle%0d: got valid=%b ready=%b count=%0d zero=%b norm=%h, want 1 0 63 0 8000000000000000",
                     i, out_valid, in_ready, out_count, out_zero, out_norm);
         end
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   // Reset during the second scan cycle aborts the word.
   task automatic test_reset_abort();
      out_ready = 1'b1;
      send_word(64'h0000_0000_0000_0001);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_count, out_zero, out_norm} !== {1'b1, 1'b0, 7'd0, 1'b0, 64'd0}) begin
         failures++;
         $display("FAIL abort_values: got ready=%b valid=%b count=%0d zero=%b norm=%h, want 1 0 0 0 0",
                  in_ready, out_valid, out_count, out_zero, out_norm);
      end
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_valid: got out_valid=%b during reset, want 0", out_valid);
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      test_directed("after_abort", 64'h00F0_0000_0000_0000, 7'd8, 1'b0, 64'hF000_0000_0000_0000);
   endtask

   // Random words with forced zero segments against random back-pressure.
   task automatic test_random(input int num);
      n_acc     = 0;
      n_out     = 0;
      rand_done = 1'b0;
      fork
         begin
            for (int w = 0; w < num; w++) begin
               logic [DATA_W-1:0] d;
               d = '0;
               for (int s = 0; s < NSEG; s++) begin
                  logic [SEG_W-1:0] sv;
                  case ($urandom_range(0, 3))
                     0:       sv = '0;
                     1:       sv = SEG_W'(1) << $urandom_range(0, SEG_W - 1);
                     default: sv = SEG_W'($urandom());
                  endcase
                  d[s*SEG_W +: SEG_W] = sv;
               end
               if ($urandom_range(0, 49) == 0) d = '0;
               repeat ($urandom_range(0, 2)) @(posedge clk);
               send_word(d);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      out_ready = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || n_acc != num || n_out != num) begin
         failures++;
         $display("FAIL random_accounting: accepted=%0d produced=%0d pending=%0d, want %0d %0d 0",
                  n_acc, n_out, exp_q.size(), num, num);
      end
   endtask

   initial begin
      test_reset();
      test_directed("msb_set", 64'h8000_0000_0000_0000, 7'd0, 1'b0, 64'h8000_0000_0000_0000);
      test_directed("bit32",   64'h0000_0001_0000_0000, 7'd31, 1'b0, 64'h8000_0000_0000_0000);
      test_directed("all_zero", 64'h0, 7'd64, 1'b1, 64'h0);
      test_directed("lsb_only", 64'h0000_0000_0000_0001, 7'd63, 1'b0, 64'h8000_0000_0000_0000);
      test_hold();
      test_reset_abort();
      test_random(2000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
